// File: rtl/la_pwrseq.sv
// Power-domain sequencer: orders isolation, power-switch enable and domain reset
// so isolation always brackets power transitions of one switchable domain.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// OFF      | domain unpowered, isolated, in reset
// PWRUP    | switch enabled, waiting for synchronized power-good
// SETTLE   | power good, holding domain reset while supply settles
// RELRST   | domain reset released, still isolated
// ON       | domain usable, isolation released
// ISOLATE  | isolation re-asserted, domain still powered and out of reset
// PWRDN    | domain reset and switch disabled, waiting for power-good to fall

module la_pwrseq #(
    parameter int SETTLE  = 4,
    parameter int RSTDLY  = 2,
    parameter int ISODLY  = 2,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic nreset,
    input  logic on,
    input  logic pwr_ok,
    output logic pwr_en,
    output logic dom_nreset,
    output logic iso,
    output logic ready,
    output logic busy,
    output logic err
);

    localparam int MAX_A = (SETTLE > RSTDLY) ? SETTLE : RSTDLY;
    localparam int MAX_B = (ISODLY > TIMEOUT) ? ISODLY : TIMEOUT;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] C_SETTLE  = CW'(SETTLE - 1);
    localparam logic [CW-1:0] C_RSTDLY  = CW'(RSTDLY - 1);
    localparam logic [CW-1:0] C_ISODLY  = CW'(ISODLY - 1);
    localparam logic [CW-1:0] C_TIMEOUT = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_OFF,
        S_PWRUP,
        S_SETTLE,
        S_RELRST,
        S_ON,
        S_ISOLATE,
        S_PWRDN
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_err;
    logic            r_lock;
    logic            w_err_nxt;
    logic            w_lock_nxt;
    logic            r_pwr_en;
    logic            r_dom_nreset;
    logic            r_iso;
    logic            r_ready;
    logic            r_busy;
    logic            w_pwr_ok_s;

    assign w_pwr_ok_s = r_sync2;

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = r_err;
        w_lock_nxt  = r_lock;
        case (r_state)
            S_OFF: begin
                if (!on) begin
                    w_lock_nxt = 1'b0;
                end else if (!r_lock) begin
                    w_state_nxt = S_PWRUP;
                    w_err_nxt   = 1'b0;
                end
            end
            S_PWRUP: begin
                if (w_pwr_ok_s) begin
                    w_state_nxt = S_SETTLE;
                end else if (r_cnt == C_TIMEOUT) begin
                    w_state_nxt = S_PWRDN;
                    w_err_nxt   = 1'b1;
                    w_lock_nxt  = 1'b1;
                end else if (!on) begin
                    w_state_nxt = S_PWRDN;
                end
            end
            S_SETTLE: begin
                if (!on) begin
                    w_state_nxt = S_PWRDN;
                end else if (r_cnt == C_SETTLE) begin
                    w_state_nxt = S_RELRST;
                end
            end
            S_RELRST: begin
                if (!on) begin
                    w_state_nxt = S_ISOLATE;
                end else if (r_cnt == C_RSTDLY) begin
                    w_state_nxt = S_ON;
                end
            end
            S_ON: begin
                // Brownout wins over a simultaneous sleep request so it is recorded.
                if (!w_pwr_ok_s) begin
                    w_state_nxt = S_ISOLATE;
                    w_err_nxt   = 1'b1;
                    w_lock_nxt  = 1'b1;
                end else if (!on) begin
                    w_state_nxt = S_ISOLATE;
                end
            end
            S_ISOLATE: begin
                if (r_cnt == C_ISODLY) begin
                    w_state_nxt = S_PWRDN;
                end
            end
            S_PWRDN: begin
                if (!w_pwr_ok_s) begin
                    w_state_nxt = S_OFF;
                end else if (r_cnt == C_TIMEOUT) begin
                    w_state_nxt = S_OFF;
                    w_err_nxt   = 1'b1;
                    w_lock_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_OFF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_state      <= S_OFF;
            r_cnt        <= '0;
            r_err        <= 1'b0;
            r_lock       <= 1'b0;
            r_pwr_en     <= 1'b0;
            r_dom_nreset <= 1'b0;
            r_iso        <= 1'b1;
            r_ready      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_sync1 <= pwr_ok;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;
            r_lock  <= w_lock_nxt;

            // Counter only runs inside the timed states and restarts on entry.
            if (w_state_nxt != r_state || w_state_nxt == S_OFF || w_state_nxt == S_ON) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end

            r_pwr_en     <= (w_state_nxt != S_OFF) && (w_state_nxt != S_PWRDN);
            r_dom_nreset <= (w_state_nxt == S_RELRST) || (w_state_nxt == S_ON) ||
                            (w_state_nxt == S_ISOLATE);
            r_iso        <= (w_state_nxt != S_ON);
            r_ready      <= (w_state_nxt == S_ON);
            r_busy       <= (w_state_nxt != S_OFF) && (w_state_nxt != S_ON);
        end
    end

    assign pwr_en     = r_pwr_en;
    assign dom_nreset = r_dom_nreset;
    assign iso        = r_iso;
    assign ready      = r_ready;
    assign busy       = r_busy;
    assign err        = r_err;

endmodule

// File: tb/tb_la_pwrseq.sv
// Bench for la_pwrseq: directed sequences then random on/pwr_ok traffic, each
// cycle compared against a phase/countdown reference model plus invariant checks.

module tb_la_pwrseq;

    localparam int P_SETTLE  = 4;
    localparam int P_RSTDLY  = 2;
    localparam int P_ISODLY  = 2;
    localparam int P_TIMEOUT = 8;

    localparam int M_OFF     = 0;
    localparam int M_PWRUP   = 1;
    localparam int M_SETTLE  = 2;
    localparam int M_RELRST  = 3;
    localparam int M_ON      = 4;
    localparam int M_ISOLATE = 5;
    localparam int M_PWRDN   = 6;

    logic clk;
    logic nreset;
    logic on;
    logic pwr_ok;
    logic pwr_en;
    logic dom_nreset;
    logic iso;
    logic ready;
    logic busy;
    logic err;

    int n_checks;
    int n_errors;

    int m_ph;
    int m_left;
    bit m_err;
    bit m_lock;
    bit m_s1;
    bit m_s2;
    logic prev_ready;

    la_pwrseq #(
        .SETTLE (P_SETTLE),
        .RSTDLY (P_RSTDLY),
        .ISODLY (P_ISODLY),
        .TIMEOUT(P_TIMEOUT)
    ) u_dut (
        .clk       (clk),
        .nreset    (nreset),
        .on        (on),
        .pwr_ok    (pwr_ok),
        .pwr_en    (pwr_en),
        .dom_nreset(dom_nreset),
        .iso       (iso),
        .ready     (ready),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [5:0] dut_outs();
        return {pwr_en, dom_nreset, iso, ready, busy, err};
    endfunction

    // {pwr_en, dom_nreset, iso, ready, busy, err}
    function automatic logic [5:0] m_outs();
        logic [4:0] v;
        case (m_ph)
            M_OFF:     v = 5'b00100;
            M_PWRUP:   v = 5'b10101;
            M_SETTLE:  v = 5'b10101;
            M_RELRST:  v = 5'b11101;
            M_ON:      v = 5'b11010;
            M_ISOLATE: v = 5'b11101;
            default:   v = 5'b00101;
        endcase
        return {v, m_err};
    endfunction

    task automatic m_reset();
        m_ph   = M_OFF;
        m_left = 0;
        m_err  = 1'b0;
        m_lock = 1'b0;
        m_s1   = 1'b0;
        m_s2   = 1'b0;
    endtask

    task automatic m_enter(input int ph, input int n);
        m_ph   = ph;
        m_left = n;
    endtask

    task automatic m_fault();
        m_err  = 1'b1;
        m_lock = 1'b1;
    endtask

    // One clock edge of the reference: m_left is the number of cycles still owed in a timed phase.
    task automatic m_step(input bit on_i, input bit ok_i);
        bit oks;
        oks  = m_s2;
        m_s2 = m_s1;
        m_s1 = ok_i;
        case (m_ph)
            M_OFF: begin
                if (!on_i) m_lock = 1'b0;
                else if (!m_lock) begin
                    m_enter(M_PWRUP, P_TIMEOUT);
                    m_err = 1'b0;
                end
            end
            M_PWRUP: begin
                if (oks) m_enter(M_SETTLE, P_SETTLE);
                else if (m_left == 1) begin
                    m_fault();
                    m_enter(M_PWRDN, P_TIMEOUT);
                end
                else if (!on_i) m_enter(M_PWRDN, P_TIMEOUT);
                else m_left--;
            end
            M_SETTLE: begin
                if (!on_i) m_enter(M_PWRDN, P_TIMEOUT);
                else if (m_left == 1) m_enter(M_RELRST, P_RSTDLY);
                else m_left--;
            end
            M_RELRST: begin
                if (!on_i) m_enter(M_ISOLATE, P_ISODLY);
                else if (m_left == 1) m_enter(M_ON, 0);
                else m_left--;
            end
            M_ON: begin
                if (!oks) begin
                    m_fault();
                    m_enter(M_ISOLATE, P_ISODLY);
                end
                else if (!on_i) m_enter(M_ISOLATE, P_ISODLY);
            end
            M_ISOLATE: begin
                if (m_left == 1) m_enter(M_PWRDN, P_TIMEOUT);
                else m_left--;
            end
            default: begin
                if (!oks) m_enter(M_OFF, 0);
                else if (m_left == 1) begin
                    m_fault();
                    m_enter(M_OFF, 0);
                end
                else m_left--;
            end
        endcase
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            m_step(on, pwr_ok);
            @(negedge clk);
            chk("outs", {2'b00, dut_outs()}, {2'b00, m_outs()});
            chk("inv_iso_only_on", {7'd0, iso | ready}, 8'd1);
            chk("inv_iso_ready_excl", {7'd0, iso & ready}, 8'd0);
            chk("inv_en_rst", {7'd0, pwr_en | ~dom_nreset}, 8'd1);
            chk("inv_iso_on_ready_fall", {7'd0, ~(prev_ready & ~ready) | iso}, 8'd1);
            prev_ready = ready;
        end
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        prev_ready = 1'b0;
        nreset     = 1'b0;
        on         = 1'b0;
        pwr_ok     = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        chk("rst_outs", {2'b00, dut_outs()}, 8'h08);
        nreset = 1'b1;

        // Wake
        on = 1'b1;
        run(3);
        pwr_ok = 1'b1;
        run(12);
        chk("wake_ready", {7'd0, ready}, 8'd1);
        chk("wake_busy", {7'd0, busy}, 8'd0);

        // Sleep
        on = 1'b0;
        run(5);
        pwr_ok = 1'b0;
        run(4);
        chk("sleep_off", {2'b00, dut_outs()}, 8'h08);

        // Timeout, lock, then re-wake by toggling on
        on = 1'b1;
        run(12);
        chk("to_err", {7'd0, err}, 8'd1);
        chk("to_pwr_en", {7'd0, pwr_en}, 8'd0);
        run(5);
        chk("to_no_rewake", {7'd0, pwr_en}, 8'd0);
        on = 1'b0;
        run(2);
        on = 1'b1;
        run(2);
        chk("rewake_err_clr", {7'd0, err}, 8'd0);
        chk("rewake_pwr_en", {7'd0, pwr_en}, 8'd1);
        pwr_ok = 1'b1;
        run(12);
        chk("rewake_ready", {7'd0, ready}, 8'd1);

        // Brownout
        pwr_ok = 1'b0;
        run(3);
        chk("bo_iso", {7'd0, iso}, 8'd1);
        chk("bo_err", {7'd0, err}, 8'd1);
        run(6);
        chk("bo_off", {7'd0, pwr_en | busy}, 8'd0);
        on = 1'b0;
        run(2);

        // Abort during SETTLE
        on = 1'b1;
        run(2);
        pwr_ok = 1'b1;
        run(4);
        on = 1'b0;
        run(2);
        chk("abort_rst_held", {7'd0, dom_nreset}, 8'd0);
        pwr_ok = 1'b0;
        run(4);

        // Async reset while in RELRST
        on = 1'b1;
        run(2);
        pwr_ok = 1'b1;
        run(7);
        chk("relrst_reached", {7'd0, dom_nreset}, 8'd1);
        #2 nreset = 1'b0;
        #1 chk("async_rst", {2'b00, dut_outs()}, 8'h08);
        m_reset();
        prev_ready = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
        on     = 1'b0;
        pwr_ok = 1'b0;
        run(3);

        // Random traffic; pwr_ok loosely follows the expected switch enable
        for (int c = 0; c < 10000; c++) begin
            int r;
            if ($urandom_range(24, 0) == 0) on = ~on;
            r = int'($urandom_range(99, 0));
            if (r < 10) pwr_ok = m_outs()[5];
            else if (r < 12) pwr_ok = ~pwr_ok;
            run(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/la_pwrseq.md
Name: la_pwrseq

Overview:
- Power-domain sequencer: the control-side counterpart of the vectorized isolation-low cell.
- Generates the isolation signal, the power-switch enable and the domain reset for one switchable domain.
- Orders them so isolation always brackets power transitions.
- Sits in the always-on domain; its iso output drives the iso pin of the domain's isolation cell vectors.

Parameters:
- SETTLE, 4, cycles held in SETTLE after power-good before releasing domain reset (>=1)
- RSTDLY, 2, cycles held in RELRST between domain reset release and isolation release (>=1)
- ISODLY, 2, cycles held in ISOLATE after isolation asserts before domain reset/power removal (>=1)
- TIMEOUT, 255, max cycles to wait for pwr_ok to rise or fall before flagging error (>=4)

Ports:
- clk  input  1  always-on clock
- nreset  input  1  asynchronous active-low reset
- on  input  1  level request: 1 = domain powered and usable, 0 = domain off
- pwr_ok  input  1  power-good from the switch network; asynchronous, double-flop synchronized internally
- pwr_en  output  1  power-switch enable
- dom_nreset  output  1  active-low reset to the switched domain
- iso  output  1  isolation control; 1 clamps domain outputs low
- ready  output  1  domain fully on, isolation released
- busy  output  1  a sequence is in progress (any state other than OFF/ON)
- err  output  1  sticky power-good timeout or brownout flag

Behaviour:
- All outputs registered (Moore, decoded from next state). Counter width is $clog2 of the largest parameter plus 1; the counter clears on every state change.
- Reset (nreset low, async): state OFF, pwr_en=0, dom_nreset=0, iso=1, ready=0, busy=0, err=0, lock=0. Synchronizer flops are cleared to 0.
- pwr_ok_s is pwr_ok after 2 flops. The FSM reacts on the 3rd edge after pwr_ok changes (edge k samples, FSM transitions at edge k+2).
- OFF: iso=1, pwr_en=0, dom_nreset=0.
  - on=0 clears lock.
  - on=1 with lock=0 goes to PWRUP and clears err.
- PWRUP: pwr_en=1, iso=1, dom_nreset=0.
  - pwr_ok_s=1 goes to SETTLE.
  - Counter reaching TIMEOUT goes to PWRDN with err=1, lock=1.
  - on=0 (abort) goes to PWRDN.
- SETTLE: held exactly SETTLE cycles, then RELRST. on=0 goes to PWRDN.
- RELRST: dom_nreset=1; held exactly RSTDLY cycles, then ON. on=0 goes to ISOLATE.
- ON: iso=0, ready=1, dom_nreset=1, pwr_en=1.
  - on=0 goes to ISOLATE.
  - pwr_ok_s=0 (brownout) goes to ISOLATE with err=1, lock=1.
- ISOLATE: iso=1, ready=0, domain still powered and out of reset; held exactly ISODLY cycles, then PWRDN. The on input is ignored.
- PWRDN: dom_nreset=0, pwr_en=0, iso=1.
  - pwr_ok_s=0 goes to OFF.
  - Counter reaching TIMEOUT sets err=1, lock=1 and goes to OFF anyway.
  - The on input is ignored.
- Invariants, checked every cycle:
  - iso=0 only in ON.
  - iso rises no later than the same edge on which ready falls.
  - pwr_en=0 implies dom_nreset=0.
- Sleep is non-abortable. on toggling during ISOLATE/PWRDN is resolved only after returning to OFF.
- lock blocks re-wake after an error until on is seen low in OFF, so there is no automatic retry loop.
- nreset asserted mid-sequence returns to the reset values immediately, including pwr_en=0. This is an abrupt power removal; the system guarantees iso=1 is already in effect via the reset value.

Test Plan:
- Wake: SETTLE=4, RSTDLY=2. Raise on, then raise pwr_ok sampled at edge k -> busy=1, pwr_en=1 one edge after on; dom_nreset rises at edge k+6; iso falls and ready rises at edge k+8; busy=0.
- Sleep from ON with ISODLY=2: drop on at edge j -> iso=1 and ready=0 at j+1; dom_nreset=0 and pwr_en=0 at j+3; after pwr_ok falls, state OFF with busy=0 two edges after sync.
- Timeout: TIMEOUT=8, pwr_ok held 0 after on=1 -> err=1 and pwr_en=0 after 8 cycles in PWRUP, back in OFF. Holding on=1 does not re-wake. Toggling on 0->1 restarts PWRUP and clears err.
- Brownout: in ON, force pwr_ok=0 -> iso=1 and err=1 within 3 edges, then full power-down to OFF; iso never 0 while pwr_en=0.
- Abort and reset: drop on during SETTLE -> PWRDN directly, dom_nreset never released. Assert nreset during RELRST -> all outputs at reset values asynchronously (iso=1, pwr_en=0, dom_nreset=0, ready=0).
- Random on/pwr_ok stimulus for 10k cycles with assertions on all invariants: no violation.
